// File: rtl/cfg_trfsm_seq.sv
// Table-driven reconfigurable Mealy/Moore sequencer. The transition rows and
// per-state output words live in one bit-serial configuration chain.
module cfg_trfsm_seq #(
    parameter int InputWidth  = 10,
    parameter int OutputWidth = 10,
    parameter int StateWidth  = 3,
    parameter int NumStates   = 8,
    parameter int NumRows     = 4,
    parameter int ResetState  = 0
) (
    input  logic                   Clk_i,
    input  logic                   Reset_i,
    input  logic [InputWidth-1:0]  Input_i,
    output logic [OutputWidth-1:0] Output_o,
    output logic [StateWidth-1:0]  State_o,
    output logic                   StateEntry_o,
    input  logic                   CfgMode_i,
    input  logic                   CfgShift_i,
    input  logic                   CfgDataIn_i,
    output logic                   CfgDataOut_o
);

    localparam int RowW    = 1 + StateWidth + 2 * InputWidth;
    localparam int RowBits = NumStates * NumRows * RowW;
    localparam int CfgLen  = RowBits + NumStates * OutputWidth;

    localparam logic [StateWidth-1:0] RstState = StateWidth'(ResetState);

    logic [CfgLen-1:0]      chain_q;
    logic [StateWidth-1:0]  state_q, state_d;
    logic [OutputWidth-1:0] out_q, out_d;
    logic                   entry_q;

    logic [RowW-1:0]        row;
    logic [InputWidth-1:0]  row_mask, row_value;
    logic [StateWidth-1:0]  row_next;
    logic                   row_valid;
    logic                   hit;

    // Rows are scanned in ascending order so the lowest matching index wins.
    always_comb begin
        state_d   = state_q;
        hit       = 1'b0;
        row       = '0;
        row_mask  = '0;
        row_value = '0;
        row_next  = '0;
        row_valid = 1'b0;
        for (int k = 0; k < NumRows; k++) begin
            row = '0;
            for (int s = 0; s < NumStates; s++) begin
                if (state_q == StateWidth'(s)) begin
                    row = chain_q[(s * NumRows + k) * RowW +: RowW];
                end
            end
            row_mask  = row[InputWidth-1:0];
            row_value = row[2*InputWidth-1:InputWidth];
            row_next  = row[2*InputWidth +: StateWidth];
            row_valid = row[RowW-1];
            if (!hit && row_valid && ((Input_i & row_mask) == (row_value & row_mask))) begin
                hit     = 1'b1;
                state_d = (32'(row_next) >= NumStates) ? RstState : row_next;
            end
        end
    end

    always_comb begin
        out_d = '0;
        for (int s = 0; s < NumStates; s++) begin
            if (state_d == StateWidth'(s)) begin
                out_d = chain_q[RowBits + s * OutputWidth +: OutputWidth];
            end
        end
    end

    // Config mode freezes the FSM at the reset state; the chain only moves then.
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            chain_q <= '0;
            state_q <= RstState;
            out_q   <= '0;
            entry_q <= 1'b0;
        end else if (CfgMode_i) begin
            state_q <= RstState;
            out_q   <= '0;
            entry_q <= 1'b0;
            if (CfgShift_i) begin
                chain_q <= {CfgDataIn_i, chain_q[CfgLen-1:1]};
            end
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            entry_q <= (state_d != state_q);
        end
    end

    assign Output_o     = out_q;
    assign State_o      = state_q;
    assign StateEntry_o = entry_q;
    assign CfgDataOut_o = chain_q[0];

endmodule

// File: doc/cfg_trfsm_seq.md
Name: cfg_trfsm_seq

Overview:
- Parametrised successor to the fixed 10-in/10-out sensor FSM wrapper: a table-driven, reconfigurable Mealy/Moore sequencer for sensor-node applications.
- State count, rows per state, input and output widths are all generic.
- Adds don't-care input masks, row valid bits, per-state registered output words, a state-entry pulse and config readback.
- Configured through a single-clock bit-serial chain and sits between the peripheral/timer status bits and the application control inputs.

Parameters:
- InputWidth, 10, width of Input_i.
- OutputWidth, 10, width of Output_o.
- StateWidth, 3, state register width.
- NumStates, 8, used states; must be ≤ 2**StateWidth.
- NumRows, 4, transition rows per state.
- ResetState, 0, state after reset, in config mode, and for out-of-range targets.

Ports:
- Clk_i  in  1  clock; all logic rising-edge.
- Reset_i  in  1  asynchronous active-high reset.
- Input_i  in  InputWidth  condition inputs, synchronous to Clk_i.
- Output_o  out  OutputWidth  registered output word of the current state.
- State_o  out  StateWidth  current state.
- StateEntry_o  out  1  one-cycle pulse after a transition into a different state.
- CfgMode_i  in  1  1 = configuration mode (FSM halted).
- CfgShift_i  in  1  shift-enable for the config chain.
- CfgDataIn_i  in  1  serial config data in.
- CfgDataOut_o  out  1  serial config data out (chain bit 0).

Behaviour:
- Derived widths:
  - RowW = 1 + StateWidth + 2*InputWidth.
  - CfgLen = NumStates*NumRows*RowW + NumStates*OutputWidth.
- Chain layout, LSB first:
  - Row records first. Record index r = s*NumRows + k, for state s and row k, occupies bits [r*RowW +: RowW].
  - Field order within a record, LSB first: Mask[InputWidth], Value[InputWidth], Next[StateWidth], Valid[1].
  - After all row records: OutWord[s] for s = 0..NumStates-1, each OutputWidth wide.
- Shift: when CfgMode_i=1 and CfgShift_i=1, chain <= {CfgDataIn_i, chain[CfgLen-1:1]}. CfgShift_i is ignored when CfgMode_i=0. CfgDataOut_o = chain[0], combinational from the register.
  - Shifting exactly CfgLen bits places the first bit shifted in at bit 0.
  - Shifting another CfgLen bits reads the old image out unchanged, one bit per shift.
- Reset (async, any time, including mid-shift):
  - Chain = all zeros, so every row is invalid.
  - State_o = ResetState, Output_o = 0, StateEntry_o = 0.
- Config mode (CfgMode_i=1): State held at ResetState, Output_o = 0, StateEntry_o = 0, no row evaluation.
- Run mode (CfgMode_i=0), every clock edge, with S = current state:
  - Row k of state S matches if Valid=1 and (Input_i & Mask) == (Value & Mask). Mask=0 means the row always matches.
  - The lowest-index matching row wins. Next state N = row.Next, or ResetState if row.Next ≥ NumStates.
  - No matching row: N = S.
  - On the edge: State <= N, Output_o <= OutWord[N], StateEntry_o <= (N != S).
  - A self-loop row sets no pulse.
- Latency: input to State_o/Output_o is 1 clock. The first run-mode edge after CfgMode_i 1→0 evaluates the ResetState rows.
- CfgMode_i 0→1 mid-run: on the next edge State = ResetState, Output_o = 0, StateEntry_o = 0. The chain contents are kept.
- No combinational path from Input_i to any output.

Test Plan:
All scenarios use InputWidth=2, OutputWidth=2, StateWidth=2, NumStates=3, NumRows=2, ResetState=0, giving RowW=7 and CfgLen=48.
- Reset/readback: after Reset_i, shift 48 bits of a pattern with CfgMode_i=1, then shift 48 zeros. CfgDataOut_o must return the pattern bit-for-bit; outputs stay 0 and State_o stays 0 throughout.
- Basic sequence: config S0 row0 (mask 01, value 01 → 1), S1 row0 (mask 10, value 10 → 2), S2 row0 (mask 00 → 0), OutWord = {S0:00, S1:01, S2:10}. Run with Input_i=01 → next cycle State_o=1, Output_o=01, StateEntry_o=1. Then Input_i=10 → State_o=2, Output_o=10, pulse. Next edge → State_o=0, Output_o=00, pulse.
- Priority/invalid/hold: S0 row0 valid (mask 11, value 11 → 2) and row1 valid (mask 01, value 01 → 1). Input_i=11 → State_o=2. Clear row0's Valid, retry → State_o=1. Input_i=00 → state holds with StateEntry_o=0.
- Out-of-range target: row Next=3 → State_o=0 with Output_o=OutWord[0]. A self-loop row produces StateEntry_o=0.
- Mode switch: in S2, raise CfgMode_i → next edge State_o=0, Output_o=00. Drop CfgMode_i → the sequence resumes from S0 with the config intact.
- Reset mid-shift: assert Reset_i after 20 shifted bits → chain all zeros. In run mode any Input_i holds State_o=0, Output_o=00.
